// File: rtl/thermo_ramp_ctrl.sv
// Thermometer-coded ramp sequencer: walks ctrl one cell per DWELL clocks toward an accepted target.
// Optional feature macro: THERMO_RAMP_RETARGET_EN (accept a new target while ramping).
module thermo_ramp_ctrl #(
    parameter int unsigned  N_ARRAY    = 47,
    parameter int unsigned  DWELL      = 10,
    parameter int unsigned  RESET_CODE = N_ARRAY,
    localparam int unsigned W          = $clog2(N_ARRAY + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tgt_valid,
    output logic               tgt_ready,
    input  logic [W-1:0]       tgt_code,
    output logic [N_ARRAY-1:0] ctrl,
    output logic [W-1:0]       cur_code,
    output logic               busy,
    output logic               done
);

    localparam int unsigned        CW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [N_ARRAY-1:0] RESET_CTRL = ~({N_ARRAY{1'b1}} << RESET_CODE);

    typedef enum logic {
        S_IDLE,
        S_RAMP
    } state_t;

    state_t             r_state, w_state_n;
    logic [W-1:0]       r_cur, w_cur_n;
    logic [W-1:0]       r_tgt, w_tgt_n;
    logic [N_ARRAY-1:0] r_ctrl, w_ctrl_n;
    logic [CW-1:0]      r_cnt, w_cnt_n;
    logic               r_done, w_done_n;

    logic [W-1:0]       w_clamped;
    logic               w_accept;
    logic               w_dwell_end;
    logic               w_up;

    assign ctrl     = r_ctrl;
    assign cur_code = r_cur;
    assign done     = r_done;
    assign busy     = (r_state == S_RAMP);

`ifdef THERMO_RAMP_RETARGET_EN
    assign tgt_ready = (r_state == S_IDLE) || (r_state == S_RAMP);
`else
    assign tgt_ready = (r_state == S_IDLE);
`endif

    assign w_clamped   = (tgt_code > W'(N_ARRAY)) ? W'(N_ARRAY) : tgt_code;
    assign w_accept    = tgt_valid && tgt_ready;
    assign w_dwell_end = (r_cnt == CW'(DWELL - 1));
    assign w_up        = (r_tgt > r_cur);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cur   <= W'(RESET_CODE);
            r_tgt   <= W'(RESET_CODE);
            r_ctrl  <= RESET_CTRL;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cur   <= w_cur_n;
            r_tgt   <= w_tgt_n;
            r_ctrl  <= w_ctrl_n;
            r_cnt   <= w_cnt_n;
            r_done  <= w_done_n;
        end
    end

    // Next-state: accept in IDLE, timed single-cell steps in RAMP
    always_comb begin
        w_state_n = r_state;
        w_cur_n   = r_cur;
        w_tgt_n   = r_tgt;
        w_ctrl_n  = r_ctrl;
        w_cnt_n   = r_cnt;
        w_done_n  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_tgt_n = w_clamped;
                    if (w_clamped == r_cur) begin
                        w_done_n = 1'b1;
                    end else begin
                        w_state_n = S_RAMP;
                        w_cnt_n   = '0;
                    end
                end
            end
            S_RAMP: begin
                if (w_dwell_end) begin
                    w_cnt_n = '0;
                    if (w_up) begin
                        w_cur_n  = r_cur + W'(1);
                        w_ctrl_n = {r_ctrl[N_ARRAY-2:0], 1'b1};
                    end else begin
                        w_cur_n  = r_cur - W'(1);
                        w_ctrl_n = {1'b0, r_ctrl[N_ARRAY-1:1]};
                    end
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
`ifdef THERMO_RAMP_RETARGET_EN
                // A step on this edge still follows the old target's direction
                if (w_accept) begin
                    w_tgt_n = w_clamped;
                end
`endif
                if (w_cur_n == w_tgt_n) begin
                    w_state_n = S_IDLE;
                    w_done_n  = 1'b1;
                    w_cnt_n   = '0;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_thermo_ramp_ctrl.sv
// Scoreboard bench for thermo_ramp_ctrl: random targets vs. an arithmetic ramp model.
// Define THERMO_RAMP_RETARGET_EN for both files to exercise the retarget build.
module tb_thermo_ramp_ctrl;

    localparam int N = 47;
    localparam int D = 10;
    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tgt_valid = 1'b0;
    logic [W-1:0] tgt_code = '0;
    logic         tgt_ready;
    logic [N-1:0] ctrl;
    logic [W-1:0] cur_code;
    logic         busy;
    logic         done;

    thermo_ramp_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_code  (tgt_code),
        .ctrl      (ctrl),
        .cur_code  (cur_code),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: a ramp from m_start to m_tgt beginning at posedge m_acc, one cell per D cycles
    int m_start = N;
    int m_tgt = N;
    int m_acc = 0;
    int m_ready_at = 0;

    typedef struct {
        int code;
        int cyc;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [N-1:0] thermo(input int n);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) if (i < n) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int exp_code(input int c);
        int steps;
        if (c >= m_ready_at) return m_tgt;
        steps = (c - m_acc) / D;
        return (m_tgt > m_start) ? m_start + steps : m_start - steps;
    endfunction

    function automatic bit exp_ready(input int c);
`ifdef THERMO_RAMP_RETARGET_EN
        return 1'b1;
`else
        return c >= m_ready_at;
`endif
    endfunction

    // Called when the driver offers code at cycle c and the block is idle: accept lands on posedge c+1
    task automatic model_accept(input int code, input int c);
        int cl;
        int d;
        cl = (code > N) ? N : code;
        m_start = exp_code(c);
        m_acc = c + 1;
        m_tgt = cl;
        d = (cl > m_start) ? cl - m_start : m_start - cl;
        m_ready_at = m_acc + d * D;
        sb.push_back('{cl, m_ready_at});
    endtask

    task automatic model_reset();
        m_start = N;
        m_tgt = N;
        m_acc = 0;
        m_ready_at = 0;
        sb.delete();
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input int code);
        int k;
        k = 0;
        while (cyc < m_ready_at && k < 1000) begin
            tick();
            k++;
        end
        tgt_valid = 1'b1;
        tgt_code = W'(code);
        model_accept(code, cyc);
        tick();
        tgt_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while ((sb.size() != 0 || cyc < m_ready_at) && k < bound) begin
            tick();
            k++;
        end
        n_cmp++;
        if (k >= bound) begin
            n_bad++;
            $display("FAIL wait_idle: timeout after %0d cycles, %0d responses pending", bound, sb.size());
        end
    endtask

    // Per-cycle check of code, thermometer shape, busy and ready against the model
    always @(negedge clk) begin
        int c;
        int e;
        if (!rst && chk_en) begin
            c = cyc;
            e = exp_code(c);
            chk("cur_code", 64'(cur_code), 64'(e));
            chk("ctrl", 64'(ctrl), 64'(thermo(e)));
            chk("busy", 64'(busy), 64'(c < m_ready_at));
            chk("tgt_ready", 64'(tgt_ready), 64'(exp_ready(c)));
        end
    end

    // Monitor: every done pulse must match the oldest expected completion
    always @(negedge clk) begin
        exp_t x;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done @cyc %0d: got done=1 expected none (cur_code=%0d)", cyc, cur_code);
            end else begin
                x = sb.pop_front();
                chk("done_code", 64'(cur_code), 64'(x.code));
                chk("done_cycle", 64'(cyc), 64'(x.cyc));
                chk("done_busy", 64'(busy), 64'(0));
            end
        end
    end

    initial begin
        int k;
        int e;
        int code;
        bit v;

        // Reset values
        #12;
        chk("rst_ctrl", 64'(ctrl), 64'h7FFF_FFFF_FFFF);
        chk("rst_cur", 64'(cur_code), 64'(N));
        chk("rst_ready", 64'(tgt_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // Clamp and no-op targets
        issue(60);
        wait_idle(50);
        issue(47);
        wait_idle(50);

        // Full ramp down
        issue(0);
        wait_idle(600);

`ifndef THERMO_RAMP_RETARGET_EN
        // Request held during a ramp is ignored until the block is idle again
        issue(5);
        tgt_valid = 1'b1;
        tgt_code = '0;
        k = 0;
        while (cyc < m_ready_at && k < 200) begin
            tick();
            k++;
        end
        model_accept(0, cyc);
        tick();
        tgt_valid = 1'b0;
        wait_idle(200);
`endif

        // Random targets, with random junk offered while busy
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) code = exp_code(cyc);
            else code = int'($urandom_range(0, 63));
`ifdef THERMO_RAMP_RETARGET_EN
            if (cyc < m_ready_at) v = 1'b0;
`endif
            tgt_valid = v;
            tgt_code = W'(code);
            if (v && cyc >= m_ready_at) model_accept(code, cyc);
            tick();
        end
        tgt_valid = 1'b0;
        wait_idle(600);

        // Asynchronous reset mid-ramp at code 20
        if (m_tgt > 20) issue(0);
        else issue(47);
        k = 0;
        while (cur_code != W'(20) && k < 600) begin
            tick();
            k++;
        end
        chk("reach_20", 64'(cur_code), 64'(20));
        #2;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_ctrl", 64'(ctrl), 64'h7FFF_FFFF_FFFF);
        chk("midrst_cur", 64'(cur_code), 64'(N));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_ready", 64'(tgt_ready), 64'(1));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_en = 1'b1;
        repeat (30) tick();

`ifdef THERMO_RAMP_RETARGET_EN
        // Retarget 0->40 to 4 at code 10: reverse, six more steps, one done
        issue(0);
        wait_idle(600);
        issue(40);
        k = 0;
        while (cur_code != W'(10) && k < 200) begin
            tick();
            k++;
        end
        chk("reach_10", 64'(cur_code), 64'(10));
        chk_en = 1'b0;
        e = cyc;
        sb.delete();
        sb.push_back('{4, e + 60});
        tgt_valid = 1'b1;
        tgt_code = W'(4);
        tick();
        tgt_valid = 1'b0;
        chk("retgt_busy", 64'(busy), 64'(1));
        while (cyc < e + 10) tick();
        chk("retgt_reverse", 64'(cur_code), 64'(9));
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            tick();
            k++;
        end
        chk("retgt_pending", 64'(sb.size()), 64'(0));
        m_start = 4;
        m_tgt = 4;
        m_acc = cyc;
        m_ready_at = cyc;
        chk_en = 1'b1;
        repeat (20) tick();
`endif

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
